// File: rtl/controlador_interrupcao_multi_pkg.sv
// Shared definitions for the multi-source interrupt controller.
//  - state_e : handshake FSM encoding (IDLE -> REQ -> SERVICE)
//  - cause register field layout and the "no cause" value
package ctrl_int_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam logic [31:0] CAUSE_NONE     = 32'h0;
  localparam int          CAUSE_ID_LSB   = 0;
  localparam int          CAUSE_ID_W     = 8;
  localparam int          CAUSE_SNAP_LSB = 16;

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational fixed-priority encoder: lowest set index wins.
//  req_i   in  N   request vector (bit 0 = highest priority)
//  idx_o   out IW  index of the winning bit (0 when none)
//  valid_o out 1   at least one request bit set
module prio_enc_lsb #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scan from the top down so the last hit (lowest index) sticks.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/controlador_interrupcao_multi.sv
// Parametrised interrupt controller between NUM_IRQ sources and the control unit.
// Per-line mask, edge/level mode, pending latches, fixed priority (bit 0 first)
// and an IDLE/REQ/SERVICE handshake that blocks nesting until software clears.
//  clk, rst_n          clock / async active-low reset
//  irq [NUM_IRQ]       requests (bit 0 = watchdog)
//  pc  [PC_WIDTH]      PC captured on ack
//  ack, clr            control-unit accept / software done
//  mask_we, mask_wdata mask write port
//  intr                request to control unit (state-decoded)
//  cause [32]          [7:0] winner+1, [31:16] masked-pending snapshot
//  pcBckp [32]         PC latched at ack, zero-extended
//  mask, pending       current mask / raw pending vector
//  busy                high in SERVICE
module controlador_interrupcao_multi
  import ctrl_int_pkg::*;
#(
  parameter int                 NUM_IRQ   = 4,
  parameter int                 PC_WIDTH  = 26,
  parameter logic [NUM_IRQ-1:0] EDGE_MODE = '0,
  parameter logic [NUM_IRQ-1:0] MASK_RST  = '1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                ack,
  input  logic                clr,
  input  logic                mask_we,
  input  logic [NUM_IRQ-1:0]  mask_wdata,
  output logic                intr,
  output logic [31:0]         cause,
  output logic [31:0]         pcBckp,
  output logic [NUM_IRQ-1:0]  mask,
  output logic [NUM_IRQ-1:0]  pending,
  output logic                busy
);

  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  state_e               state_q, state_d;
  logic [NUM_IRQ-1:0]   irq_q;
  logic [NUM_IRQ-1:0]   pend_q, pend_d;
  logic [NUM_IRQ-1:0]   mask_q, mask_d;
  logic [31:0]          cause_q, cause_d;
  logic [31:0]          pcbk_q, pcbk_d;
  logic [NUM_IRQ-1:0]   masked;
  logic [NUM_IRQ-1:0]   ack_clr;
  logic [IW-1:0]        win_idx;
  logic                 win_vld;
  logic                 take;

  assign masked = pend_q & mask_q;

  prio_enc_lsb #(.N(NUM_IRQ)) u_prio (
    .req_i   (masked),
    .idx_o   (win_idx),
    .valid_o (win_vld)
  );

  // FSM + cause/pcBckp capture
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pcbk_d  = pcbk_q;
    take    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (win_vld) state_d = ST_REQ;
      ST_REQ: begin
        // Withdrawal takes precedence: with nothing left there is no winner to report.
        if (!win_vld) begin
          state_d = ST_IDLE;
        end else if (ack) begin
          take    = 1'b1;
          state_d = ST_SERVICE;
          cause_d = CAUSE_NONE;
          cause_d[CAUSE_ID_LSB +: CAUSE_ID_W]  = CAUSE_ID_W'(win_idx) + CAUSE_ID_W'(1);
          cause_d[CAUSE_SNAP_LSB +: NUM_IRQ]   = masked;
          pcbk_d  = 32'(pc);
        end
      end
      ST_SERVICE: if (clr) begin
        state_d = ST_IDLE;
        cause_d = CAUSE_NONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One-hot clear of the acknowledged line.
  always_comb begin
    ack_clr = '0;
    if (take) ack_clr[win_idx] = 1'b1;
  end

  // Pending next-state per line; an edge set beats a same-cycle ack clear.
  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_pend
    if (EDGE_MODE[g]) begin : g_edge
      assign pend_d[g] = (irq[g] & ~irq_q[g]) | (pend_q[g] & ~ack_clr[g]);
    end else begin : g_level
      assign pend_d[g] = irq[g];
    end
  end

  assign mask_d = mask_we ? mask_wdata : mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      irq_q   <= '0;       // a line high at reset release looks like an edge
      pend_q  <= '0;
      mask_q  <= MASK_RST;
      cause_q <= CAUSE_NONE;
      pcbk_q  <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      cause_q <= cause_d;
      pcbk_q  <= pcbk_d;
    end
  end

  assign intr    = (state_q == ST_REQ);
  assign busy    = (state_q == ST_SERVICE);
  assign cause   = cause_q;
  assign pcBckp  = pcbk_q;
  assign mask    = mask_q;
  assign pending = pend_q;

endmodule
